// File: rtl/ret_stack.sv
// Return-address stack: call/interrupt push, pop, same-cycle replace, sticky ovf/unf, optional wrap.
// Updates on clk and is visible the next cycle. There is no backpressure; full/empty/ovf/unf report misuse.
module ret_stack #(
    parameter int AW    = 10,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       push_intr,
    input  logic                       pop,
    input  logic [AW-1:0]              dato,
    input  logic                       err_clr,
    output logic [AW-1:0]              top,
    output logic                       top_intr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);
    localparam int SW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW:0]    mem [DEPTH];
    logic [SW-1:0]  sp;
    logic [AW:0]    wr_val;
    logic [SW-1:0]  wr_idx;
    logic           p;
    logic           do_repl;
    logic           do_push;
    logic           do_pop;
    logic           ovf_set;
    logic           unf_set;

    assign p      = push | push_intr;
    // Interrupt entries keep the interrupted PC; calls store the return address.
    assign wr_val = push_intr ? {1'b1, dato} : {1'b0, dato + AW'(1)};

    // A push+pop on an empty stack falls through to a plain push.
    assign do_repl = p & pop & ~empty;
    assign do_push = p & ~do_repl & (~full | (WRAP != 0));
    assign do_pop  = ~p & pop & ~empty;
    assign ovf_set = p & ~pop & full;
    assign unf_set = ~p & pop & empty;
    assign wr_idx  = do_repl ? sp : sp + SW'(1);

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top      = empty ? '0 : mem[sp][AW-1:0];
    assign top_intr = empty ? 1'b0 : mem[sp][AW];

    always_ff @(posedge clk) begin
        if (do_repl | do_push)
            mem[wr_idx] <= wr_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (do_push)
                sp <= sp + SW'(1);
            else if (do_pop)
                sp <= sp - SW'(1);

            if (do_push & ~full)
                count <= count + CW'(1);
            else if (do_pop)
                count <= count - CW'(1);

            // Set wins over a simultaneous clear.
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end
endmodule

// File: tb/tb_ret_stack.sv
// Bench for ret_stack: WRAP=0 and WRAP=1 instances share stimulus and are checked against a queue model.
module tb_ret_stack;
    localparam int AW = 10;
    localparam int DEPTH = 16;
    typedef logic [AW:0] ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic push = 1'b0, push_intr = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [AW-1:0] dato = '0;

    logic [AW-1:0] top0, top1;
    logic [4:0]    count0, count1;
    logic          tint0, tint1, empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    ret_stack #(.AW(AW), .DEPTH(DEPTH), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .push(push), .push_intr(push_intr), .pop(pop),
        .dato(dato), .err_clr(err_clr), .top(top0), .top_intr(tint0), .count(count0),
        .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0));

    ret_stack #(.AW(AW), .DEPTH(DEPTH), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .push(push), .push_intr(push_intr), .pop(pop),
        .dato(dato), .err_clr(err_clr), .top(top1), .top_intr(tint1), .count(count1),
        .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1));

    // Model: back of queue is the top of stack; index 0 is WRAP=0, 1 is WRAP=1.
    ent_t mq [2][$];
    bit   movf [2];
    bit   munf [2];
    bit   so, su, mp;
    ent_t mv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < 2; w++) begin
                mq[w].delete();
                movf[w] = 1'b0;
                munf[w] = 1'b0;
            end
        end else begin
            mp = push | push_intr;
            mv = push_intr ? {1'b1, dato} : {1'b0, dato + 10'd1};
            for (int w = 0; w < 2; w++) begin
                so = 1'b0;
                su = 1'b0;
                if (mp && pop && mq[w].size() > 0) begin
                    mq[w][mq[w].size() - 1] = mv;
                end else if (mp) begin
                    if (mq[w].size() < DEPTH) begin
                        mq[w].push_back(mv);
                    end else begin
                        so = 1'b1;
                        if (w == 1) begin
                            void'(mq[w].pop_front());
                            mq[w].push_back(mv);
                        end
                    end
                end else if (pop) begin
                    if (mq[w].size() > 0) void'(mq[w].pop_back());
                    else su = 1'b1;
                end
                movf[w] = so | (movf[w] & ~err_clr);
                munf[w] = su | (munf[w] & ~err_clr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input int w, input logic [AW-1:0] t, input logic ti, input logic [4:0] c,
                           input logic e, input logic f, input logic o, input logic u);
        int   n;
        ent_t tp;
        n  = mq[w].size();
        tp = (n > 0) ? mq[w][n - 1] : '0;
        check($sformatf("dut%0d.count", w), 32'(c), 32'(n));
        check($sformatf("dut%0d.top", w), 32'(t), 32'(tp[AW-1:0]));
        check($sformatf("dut%0d.top_intr", w), 32'(ti), 32'(tp[AW]));
        check($sformatf("dut%0d.empty", w), 32'(e), 32'(n == 0));
        check($sformatf("dut%0d.full", w), 32'(f), 32'(n == DEPTH));
        check($sformatf("dut%0d.ovf", w), 32'(o), 32'(movf[w]));
        check($sformatf("dut%0d.unf", w), 32'(u), 32'(munf[w]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, top0, tint0, count0, empty0, full0, ovf0, unf0);
        cmp_dut(1, top1, tint1, count1, empty1, full1, ovf1, unf1);
    end

    // Inputs are applied 2 time units after a rising edge; returns after the edge that consumes them.
    task automatic step(input logic pu, input logic pi, input logic po,
                        input logic [AW-1:0] d, input logic clr);
        push = pu; push_intr = pi; pop = po; dato = d; err_clr = clr;
        @(posedge clk);
        #2;
        push = 1'b0; push_intr = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #12 reset = 1'b0;
        check("reset count", 32'(count0), 0);
        check("reset empty", 32'(empty0), 1);
        check("reset full", 32'(full1), 0);
        check("reset top", 32'(top1), 0);

        // Call pushes store PC+1, wrapping 0x3FF to 0.
        step(1, 0, 0, 10'h010, 0);
        step(1, 0, 0, 10'h020, 0);
        step(1, 0, 0, 10'h3FF, 0);
        check("call top wrap", 32'(top0), 32'h000);
        check("call count", 32'(count0), 3);
        step(0, 0, 1, 0, 0);
        check("pop top 021", 32'(top0), 32'h021);
        step(0, 0, 1, 0, 0);
        check("pop top 011", 32'(top0), 32'h011);
        check("pop tag 0", 32'(tint0), 0);
        step(0, 0, 1, 0, 0);
        check("pop empty", 32'(empty0), 1);
        check("pop empty top", 32'(top0), 0);

        // Interrupt pushes keep the PC and tag the entry.
        step(0, 1, 0, 10'h155, 0);
        step(1, 0, 0, 10'h100, 0);
        check("intr then call top", 32'(top0), 32'h101);
        check("intr then call tag", 32'(tint0), 0);
        step(0, 0, 1, 0, 0);
        check("intr top", 32'(top1), 32'h155);
        check("intr tag", 32'(tint1), 1);
        step(1, 1, 0, 10'h0AA, 0);
        check("both push top", 32'(top0), 32'h0AA);
        check("both push tag", 32'(tint0), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Overflow: WRAP=0 rejects, WRAP=1 overwrites the oldest.
        for (int i = 1; i <= 17; i++) step(1, 0, 0, 10'(i), 0);
        check("w0 full", 32'(full0), 1);
        check("w0 count", 32'(count0), 16);
        check("w0 top", 32'(top0), 17);
        check("w0 ovf", 32'(ovf0), 1);
        check("w1 count", 32'(count1), 16);
        check("w1 top", 32'(top1), 18);
        check("w1 ovf", 32'(ovf1), 1);
        step(0, 0, 0, 0, 1);
        check("w0 ovf cleared", 32'(ovf0), 0);
        check("w1 ovf cleared", 32'(ovf1), 0);
        for (int i = 0; i < 16; i++) begin
            check("w1 drain top", 32'(top1), 32'(18 - i));
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 1, 0, 0);
        check("w1 unf", 32'(unf1), 1);
        check("w0 unf", 32'(unf0), 1);
        check("unf count", 32'(count0), 0);
        step(0, 0, 0, 0, 1);

        // Replace: top rewritten, lower entry untouched; on empty it is a plain push.
        step(1, 0, 0, 10'h030, 0);
        step(1, 0, 0, 10'h031, 0);
        step(1, 0, 1, 10'h040, 0);
        check("repl count", 32'(count0), 2);
        check("repl top", 32'(top0), 32'h041);
        step(0, 0, 1, 0, 0);
        check("repl lower", 32'(top0), 32'h031);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 10'h050, 0);
        check("repl empty count", 32'(count0), 1);
        check("repl empty unf", 32'(unf0), 0);
        check("repl empty top", 32'(top0), 32'h051);

        // Asynchronous reset with five entries, checked before any clock edge.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 10'(i), 0);
        check("pre-reset count", 32'(count1), 5);
        #1 reset = 1'b1;
        #1;
        check("async count", 32'(count0), 0);
        check("async empty", 32'(empty1), 1);
        check("async top", 32'(top0), 0);
        check("async flags", 32'({ovf0, unf0, ovf1, unf1}), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Replace while full raises no error.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 10'(i + 100), 0);
        step(1, 0, 1, 10'h3FF, 0);
        check("full repl ovf", 32'(ovf0), 0);
        check("full repl top", 32'(top0), 0);
        check("full repl count", 32'(count1), 16);

        // Randomized phase with push/pop bias alternating to reach both full and empty.
        for (int i = 0; i < 2400; i++) begin
            int bias;
            bias = ((i / 150) % 2 == 0) ? 60 : 25;
            push      = ($urandom_range(0, 99) < bias);
            push_intr = ($urandom_range(0, 99) < bias / 3);
            pop       = ($urandom_range(0, 99) < 85 - bias);
            err_clr   = ($urandom_range(0, 15) == 0);
            dato      = 10'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b1;
                #1 check("rand async count", 32'(count1), 0);
                @(posedge clk);
                #2 reset = 1'b0;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        push = 1'b0; push_intr = 1'b0; pop = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
